cover_toggle_collector: RTL and testbench
=========================================

Name: cover_toggle_collector

Overview:
- Synthesizable, parametrised toggle-coverage collector. It replaces per-cycle DPI reporting with on-chip first-hit tracking.
- Records the first assertion of each of WIDTH cover points in a sticky bitmap.
- Serialises newly hit points, lowest index first, into a FIFO of global cover indices.
- The FIFO drains over a valid/ready stream. Running hit count and completion status are also exported.
- Sits beside each instrumented module; the stream feeds the coverage aggregator or FPGA host link.

Parameters:
- WIDTH, 40, number of local cover points (>=1).
- COVER_INDEX, 0, global index of local point 0.
- COVER_TOTAL, 8744, total global cover points; elaboration check: COVER_INDEX+WIDTH <= COVER_TOTAL.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).
- IDX_W, 32, width of emitted index.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- valid  in  WIDTH  per-point hit strobe, sampled every cycle.
- clear  in  1  synchronous clear of coverage state.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_index  out  IDX_W  COVER_INDEX + local point number.
- hit_count  out  $clog2(WIDTH+1)  number of points hit since reset/clear.
- all_hit  out  1  hit_count == WIDTH.
- busy  out  1  pending bitmap nonzero or FIFO nonempty.

Behaviour:
- Reset (synchronous, active-high): hit_map, pending, FIFO, hit_count all cleared. Outputs: out_valid=0, out_index=0, hit_count=0, all_hit=0, busy=0. Reset overrides clear and all inputs.
- new_hits = valid & ~hit_map. At each edge with reset=0 and clear=0:
  - hit_map |= new_hits
  - pending |= new_hits
  - hit_count += popcount(new_hits)
- Repeat assertions of an already-hit point are ignored and never re-emitted.
- Serialiser picks sel = lowest set bit of the current pending register (pre-update value).
- Push condition: pending!=0 and (fifo_count<FIFO_DEPTH or pop this cycle). On push: FIFO receives COVER_INDEX+sel, truncated/zero-extended to IDX_W, and pending[sel] clears.
- At most one push per cycle.
- Pop occurs when out_valid && out_ready. Simultaneous push and pop is legal at any occupancy, including full, and count is unchanged.
- out_valid/out_index come from FIFO head registers. out_index holds its value while out_valid && !out_ready.
- Latency: valid[i] first high at cycle n gives pending[i]=1 at n+1, pushed at edge n+1 (if selected and space), out_valid at n+2 when the FIFO was empty.
- Throughput is one index per cycle. A burst of k new hits drains in k cycles under continuous out_ready.
- Full FIFO with out_ready=0: pending bits accumulate without loss. Bitmap capacity is WIDTH, so no overflow condition exists.
- clear=1 (reset=0): hit_map, pending and hit_count are zeroed. valid is ignored that cycle and no push occurs. The FIFO is untouched and keeps draining.
- A pop coinciding with clear is honoured.
- all_hit and busy are combinational from registered state.
- Single clock domain. No DPI in this block.

Test Plan (WIDTH=40, COVER_INDEX=100, FIFO_DEPTH=4, IDX_W=32):
1. Reset then valid=1<<5 for one cycle, out_ready=1 -> out_valid high exactly 2 cycles later with out_index=105 for one cycle; hit_count=1; busy low afterwards.
2. valid=bits {3,7,39} in one cycle, out_ready=1 -> indices 103,107,139 on consecutive cycles; hit_count=3 the cycle after the strobe.
3. valid bit 5 held high 10 cycles -> exactly one emission of 105; hit_count stays 1.
4. out_ready=0, valid=bits 0..9 in one cycle -> FIFO fills with 100..103, out_valid held with out_index=100, pending holds 4..9, busy=1. Then out_ready=1 -> 100..109 emitted in order, one per cycle, none lost or duplicated.
5. Drive all 40 bits over several cycles -> all_hit=1 when hit_count=40. Then pulse clear with valid=bit 2 asserted the same cycle -> hit_count=0, all_hit=0, bit 2 not recorded. FIFO entries already queued still drain.
6. Assert reset mid-drain with FIFO holding 3 entries and pending nonzero -> next cycle out_valid=0, busy=0, hit_count=0. Re-hitting bit 0 afterwards emits 100.

Source files
------------

// File: rtl/cover_toggle_collector.sv
`default_nettype none
// ============================================================================
// Module   : cover_toggle_collector
// Brief    : Sticky first-hit toggle coverage with serialised index stream.
// Revision : 1.0
// ============================================================================
module cover_toggle_collector #(
  parameter int WIDTH       = 40,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 8744,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDX_W       = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             out_index,
  output logic [$clog2(WIDTH+1)-1:0]   hit_count,
  output logic                         all_hit,
  output logic                         busy
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [c_PTR_W:0]   c_DEPTH    = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_WIDTH    = c_CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0]   c_MAP_ONE  = WIDTH'(1);
  localparam logic [IDX_W-1:0]   c_BASE     = IDX_W'(COVER_INDEX);

  generate
    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
      $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end
    if ((FIFO_DEPTH < 2) || ((1 << c_PTR_W) != FIFO_DEPTH)) begin : g_bad_depth
      $error("cover_toggle_collector: FIFO_DEPTH must be a power of two >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("cover_toggle_collector: WIDTH must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0]   r_hit_map;
  logic [WIDTH-1:0]   r_pending;
  logic [c_CNT_W-1:0] r_hit_count;

  logic [IDX_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic [WIDTH-1:0]   w_new_hits;
  logic [WIDTH-1:0]   w_lowest;
  logic [c_CNT_W-1:0] w_new_cnt;
  logic [c_SEL_W-1:0] w_sel;
  logic [IDX_W-1:0]   w_push_index;
  logic               w_full;
  logic               w_pop;
  logic               w_push;

  assign w_new_hits = valid & ~r_hit_map;

  // Two's-complement trick isolates the lowest pending bit as a one-hot mask.
  assign w_lowest = r_pending & (~r_pending + c_MAP_ONE);

  always_comb begin
    w_new_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_new_cnt = w_new_cnt + c_CNT_W'(w_new_hits[i]);
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_sel = c_SEL_W'(i);
      end
    end
  end

  assign w_push_index = c_BASE + IDX_W'(w_sel);
  assign w_full       = (r_count == c_DEPTH);
  assign out_valid    = (r_count != '0);
  assign w_pop        = out_valid && out_ready;
  assign w_push       = !clear && (r_pending != '0) && (!w_full || w_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hit_map   <= '0;
      r_pending   <= '0;
      r_hit_count <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (clear) begin
        r_hit_map   <= '0;
        r_pending   <= '0;
        r_hit_count <= '0;
      end else begin
        r_hit_map   <= r_hit_map | w_new_hits;
        r_pending   <= (r_pending & ~(w_push ? w_lowest : '0)) | w_new_hits;
        r_hit_count <= r_hit_count + w_new_cnt;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is only visible while out_valid is high.
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= w_push_index;
    end
  end

  assign out_index = out_valid ? r_mem[r_rd_ptr] : '0;
  assign hit_count = r_hit_count;
  assign all_hit   = (r_hit_count == c_WIDTH);
  assign busy      = (r_pending != '0) || out_valid;

endmodule
`default_nettype wire

// File: tb/tb_cover_toggle_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cover_toggle_collector
// Brief    : Table, directed and random checks of cover_toggle_collector.
// Revision : 1.0
// ============================================================================
module tb_cover_toggle_collector;

  localparam int WIDTH = 40;
  localparam int CI    = 100;
  localparam int DEPTH = 4;
  localparam int IDX_W = 32;

  logic              clock;
  logic              reset;
  logic [WIDTH-1:0]  valid;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_index;
  logic [5:0]        hit_count;
  logic              all_hit;
  logic              busy;

  cover_toggle_collector #(
    .WIDTH(WIDTH), .COVER_INDEX(CI), .COVER_TOTAL(8744),
    .FIFO_DEPTH(DEPTH), .IDX_W(IDX_W)
  ) dut (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .hit_count(hit_count), .all_hit(all_hit), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: set of hit points, set of unreported points, output queue.
  bit m_hit  [WIDTH];
  bit m_pend [WIDTH];
  int m_q    [$];
  int m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [WIDTH-1:0] v, input bit clr, input bit rdy, input bit rst);
    bit pop;
    bit push;
    int sel;
    if (rst) begin
      foreach (m_hit[i]) begin
        m_hit[i]  = 0;
        m_pend[i] = 0;
      end
      m_q.delete();
      m_cnt = 0;
    end else begin
      pop = (m_q.size() > 0) && rdy;
      sel = -1;
      for (int i = 0; i < WIDTH; i++) begin
        if (m_pend[i] && sel < 0) sel = i;
      end
      push = !clr && (sel >= 0) && ((m_q.size() < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(CI + sel);
        m_pend[sel] = 0;
      end
      if (clr) begin
        foreach (m_hit[i]) begin
          m_hit[i]  = 0;
          m_pend[i] = 0;
        end
        m_cnt = 0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (v[i] && !m_hit[i]) begin
            m_hit[i]  = 1;
            m_pend[i] = 1;
            m_cnt++;
          end
        end
      end
    end
  endtask

  task automatic model_check();
    bit any;
    any = 0;
    foreach (m_pend[i]) any |= m_pend[i];
    chk("model.out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("model.out_index", out_index, m_q[0]);
    chk("model.hit_count", hit_count, m_cnt);
    chk("model.all_hit", all_hit, m_cnt == WIDTH);
    chk("model.busy", busy, any || (m_q.size() > 0));
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare after the edge.
  task automatic apply(input logic [WIDTH-1:0] v, input bit clr, input bit rdy, input bit rst);
    valid     = v;
    clear     = clr;
    out_ready = rdy;
    reset     = rst;
    model_step(v, clr, rdy, rst);
    @(posedge clock);
    #1;
    model_check();
  endtask

  typedef struct {
    logic [WIDTH-1:0] v;
    bit               clr;
    bit               rdy;
    bit               rst;
    bit               ov;
    bit               ci;
    logic [IDX_W-1:0] idx;
    logic [5:0]       hc;
    bit               all;
    bit               bsy;
  } vec_t;

  function automatic vec_t mkv(input logic [WIDTH-1:0] v, input bit clr, input bit rdy,
                               input bit rst, input bit ov, input bit ci,
                               input logic [IDX_W-1:0] idx, input logic [5:0] hc,
                               input bit all, input bit bsy);
    vec_t r;
    r.v = v; r.clr = clr; r.rdy = rdy; r.rst = rst; r.ov = ov; r.ci = ci;
    r.idx = idx; r.hc = hc; r.all = all; r.bsy = bsy;
    return r;
  endfunction

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] one;
    int               ems;
    int               got [$];
    bit               seen;
    logic [WIDTH-1:0] rv;

    one = 1;
    valid = '0; clear = 0; out_ready = 0; reset = 1;

    //            v              clr rdy rst ov ci idx  hc all bsy
    tbl[0]  = mkv('0,            0,  1,  1,  0, 1, 0,   0, 0, 0);
    tbl[1]  = mkv(one << 5,      0,  1,  0,  0, 0, 0,   1, 0, 1);
    tbl[2]  = mkv('0,            0,  1,  0,  1, 1, 105, 1, 0, 1);
    tbl[3]  = mkv('0,            0,  1,  0,  0, 0, 0,   1, 0, 0);
    tbl[4]  = mkv('0,            0,  1,  0,  0, 0, 0,   1, 0, 0);
    tbl[5]  = mkv(one << 7,      0,  1,  1,  0, 1, 0,   0, 0, 0);
    tbl[6]  = mkv((one << 3) | (one << 7) | (one << 39),
                                 0,  1,  0,  0, 0, 0,   3, 0, 1);
    tbl[7]  = mkv('0,            0,  1,  0,  1, 1, 103, 3, 0, 1);
    tbl[8]  = mkv('0,            0,  1,  0,  1, 1, 107, 3, 0, 1);
    tbl[9]  = mkv('0,            0,  1,  0,  1, 1, 139, 3, 0, 1);
    tbl[10] = mkv('0,            0,  1,  0,  0, 0, 0,   3, 0, 0);
    tbl[11] = mkv(one << 3,      0,  1,  0,  0, 0, 0,   3, 0, 0);

    apply('0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].v, tbl[i].clr, tbl[i].rdy, tbl[i].rst);
      chk($sformatf("vec%0d.out_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].ci) chk($sformatf("vec%0d.out_index", i), out_index, tbl[i].idx);
      chk($sformatf("vec%0d.hit_count", i), hit_count, tbl[i].hc);
      chk($sformatf("vec%0d.all_hit", i), all_hit, tbl[i].all);
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].bsy);
    end

    // Held strobe is reported once.
    apply('0, 0, 1, 1);
    ems = 0;
    for (int k = 0; k < 13; k++) begin
      apply(k < 10 ? (one << 5) : '0, 0, 1, 0);
      if (out_valid) ems++;
    end
    chk("t3.emissions", ems, 1);
    chk("t3.hit_count", hit_count, 1);

    // Backpressure: FIFO fills, pending holds the rest, then ordered drain.
    apply('0, 0, 0, 1);
    apply(40'h3FF, 0, 0, 0);
    for (int k = 0; k < 6; k++) apply('0, 0, 0, 0);
    chk("t4.out_valid", out_valid, 1);
    chk("t4.out_index", out_index, 100);
    chk("t4.busy", busy, 1);
    chk("t4.hit_count", hit_count, 10);
    got.delete();
    for (int k = 0; k < 20; k++) begin
      if (out_valid) got.push_back(int'(out_index));
      apply('0, 0, 1, 0);
    end
    chk("t4.drain_len", got.size(), 10);
    for (int j = 0; j < 10 && j < got.size(); j++) chk($sformatf("t4.drain%0d", j), got[j], 100 + j);
    chk("t4.busy_end", busy, 0);

    // Full coverage, then clear with a coincident strobe and pop.
    apply('0, 0, 0, 1);
    for (int c = 0; c < 5; c++) apply(40'hFF << (8 * c), 0, 0, 0);
    chk("t5.hit_count", hit_count, 40);
    chk("t5.all_hit", all_hit, 1);
    apply(one << 2, 1, 1, 0);
    chk("t5.clr_hit_count", hit_count, 0);
    chk("t5.clr_all_hit", all_hit, 0);
    chk("t5.clr_out_valid", out_valid, 1);
    chk("t5.clr_out_index", out_index, 101);
    ems = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) ems++;
      apply('0, 0, 1, 0);
    end
    chk("t5.drained", ems, 3);
    chk("t5.bit2_not_recorded", hit_count, 0);
    chk("t5.busy_end", busy, 0);

    // Reset while draining.
    apply('0, 0, 0, 1);
    apply(40'h3FF, 0, 0, 0);
    for (int k = 0; k < 3; k++) apply('0, 0, 0, 0);
    chk("t6.pre_busy", busy, 1);
    apply('0, 0, 0, 1);
    chk("t6.out_valid", out_valid, 0);
    chk("t6.busy", busy, 0);
    chk("t6.hit_count", hit_count, 0);
    apply(one, 0, 1, 0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid && !seen) begin
        seen = 1;
        chk("t6.rehit_index", out_index, 100);
      end
      apply('0, 0, 1, 0);
    end
    chk("t6.rehit_seen", seen, 1);

    // Random traffic against the model.
    apply('0, 0, 0, 1);
    for (int k = 0; k < 3000; k++) begin
      rv = {8'($urandom), $urandom} & {8'($urandom), $urandom}
         & {8'($urandom), $urandom} & {8'($urandom), $urandom};
      apply(rv, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 499) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
